// File: rtl/ena_gen_multi.sv
// ena_gen_multi: multi-channel clock-enable generator.
//
// Each of NUM_CH channels divides ckht by its own runtime-programmable
// divisor and produces a one-cycle enable pulse (tick) plus a 50 % square
// wave (sq) that toggles on every tick. New divisors land in a per-channel
// shadow register and only take effect at the channel's wrap, while the
// channel is stopped, or on a sync_clr. A running period is therefore never
// cut short or stretched by a write.
//
// Ports:
//   ckht      in   system clock, rising-edge active
//   rst_n     in   synchronous reset, active-low
//   run       in   per-channel count enable
//   sync_clr  in   synchronous restart / phase alignment of all channels
//   wr_en     in   divisor write strobe
//   wr_ch     in   target channel of the write (>= NUM_CH is ignored)
//   wr_div    in   new divisor value (0 behaves as 1)
//   tick      out  registered one-cycle enable pulse per channel
//   sq        out  registered square wave per channel
//   pending   out  shadow divisor written but not yet active
//
// Write port: wr_en is a single-cycle strobe with no back-pressure. A write
// is accepted on every ckht edge where wr_en=1 and wr_ch<NUM_CH; there is
// no ready signal and no write is ever stalled or dropped for a valid
// channel.
//
// Priority on every edge: rst_n > sync_clr > write/count.

module ena_gen_multi #(
  parameter int CLK_HZ  = 50000000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = CLK_HZ / 1000
) (
  input  logic              ckht,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] run,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  div [NUM_CH];
  logic [CNT_W-1:0]  shd [NUM_CH];
  logic [CNT_W-1:0]  lim [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] wr_hit;

  // lim is the last count value of a period (D-1), with a divisor of 0
  // treated as 1. The wrap test uses >= so that a counter left above a
  // smaller divisor applied while stopped wraps at once instead of running
  // all the way around 2^CNT_W.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lim[i]    = (div[i] == '0) ? '0 : div[i] - 1'b1;
      wrap[i]   = run[i] && (cnt[i] >= lim[i]);
      wr_hit[i] = wr_en && (wr_ch == 4'(i));
    end
  end

  always_ff @(posedge ckht) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= DEF_VAL;
        shd[i] <= DEF_VAL;
      end
      tick    <= '0;
      sq      <= '0;
      pending <= '0;
    end else if (sync_clr) begin
      // Restart every channel at phase 0. A write on this edge goes straight
      // into the active divisor; otherwise any pending shadow is adopted.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        if (wr_hit[i]) begin
          div[i] <= wr_div;
          shd[i] <= wr_div;
        end else if (pending[i]) begin
          div[i] <= shd[i];
        end
      end
      tick    <= '0;
      sq      <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrap[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          sq[i]   <= ~sq[i];
        end else begin
          if (run[i]) begin
            cnt[i] <= cnt[i] + 1'b1;
          end
          tick[i] <= 1'b0;
        end
        // Shadow is adopted at the wrap or whenever the channel is stopped.
        // This reads the shadow before the write below updates it, so a
        // write colliding with a wrap stays pending for the next period.
        if (pending[i] && (wrap[i] || !run[i])) begin
          div[i]     <= shd[i];
          pending[i] <= 1'b0;
        end
        if (wr_hit[i]) begin
          shd[i]     <= wr_div;
          pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ena_gen_multi.sv
module tb_ena_gen_multi;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int DD = 4;

  logic          ckht;
  logic          rst_n;
  logic [NC-1:0] run;
  logic          sync_clr;
  logic          wr_en;
  logic [3:0]    wr_ch;
  logic [CW-1:0] wr_div;
  logic [NC-1:0] tick;
  logic [NC-1:0] sq;
  logic [NC-1:0] pending;

  int total;
  int bad;

  // reference model state: phase within period, divisors, outputs
  int            m_cnt [NC];
  int            m_div [NC];
  int            m_shd [NC];
  logic [NC-1:0] m_tick;
  logic [NC-1:0] m_sq;
  logic [NC-1:0] m_pend;

  ena_gen_multi #(
    .CLK_HZ (4000),
    .NUM_CH (NC),
    .CNT_W  (CW),
    .DEF_DIV(DD)
  ) dut (
    .ckht    (ckht),
    .rst_n   (rst_n),
    .run     (run),
    .sync_clr(sync_clr),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .tick    (tick),
    .sq      (sq),
    .pending (pending)
  );

  // clock / reset block
  initial begin
    ckht = 1'b0;
    forever #5 ckht = ~ckht;
  end

  // Behavioural model: a channel emits a pulse once it has counted D edges
  // in the current period; a new divisor is only adopted at a period
  // boundary, while stopped, or on a restart.
  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      if (!rst_n) begin
        m_cnt[c] = 0; m_div[c] = DD; m_shd[c] = DD;
        m_tick[c] = 1'b0; m_sq[c] = 1'b0; m_pend[c] = 1'b0;
      end else if (sync_clr) begin
        m_cnt[c] = 0; m_tick[c] = 1'b0; m_sq[c] = 1'b0;
        if (wr_en && int'(wr_ch) == c) begin
          m_div[c] = int'(wr_div); m_shd[c] = int'(wr_div);
        end else if (m_pend[c]) begin
          m_div[c] = m_shd[c];
        end
        m_pend[c] = 1'b0;
      end else begin
        int  eff;
        bit  boundary;
        eff = (m_div[c] == 0) ? 1 : m_div[c];
        boundary = run[c] && (m_cnt[c] + 1 >= eff);
        if (m_pend[c] && (boundary || !run[c])) begin
          m_div[c] = m_shd[c];
          m_pend[c] = 1'b0;
        end
        if (boundary) begin
          m_cnt[c] = 0; m_tick[c] = 1'b1; m_sq[c] = ~m_sq[c];
        end else begin
          if (run[c]) m_cnt[c] = m_cnt[c] + 1;
          m_tick[c] = 1'b0;
        end
        if (wr_en && int'(wr_ch) == c) begin
          m_shd[c] = int'(wr_div);
          m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  // driver: one rising edge, model follows, return on falling edge
  task automatic step();
    @(posedge ckht);
    model_edge();
    @(negedge ckht);
  endtask

  task automatic idle_inputs();
    sync_clr = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = 4'd0;
    wr_div   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 4'hF;
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    total++;
    if ({tick, sq, pending} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=000", {tick, sq, pending});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic [NC-1:0] et;
      logic [NC-1:0] es;
      step();
      et = (k % 4 == 0) ? 4'hF : 4'h0;
      es = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
      total++;
      if (tick !== et) begin
        bad++;
        $display("FAIL reset_tick k=%0d got=%h exp=%h", k, tick, et);
      end
      total++;
      if (sq !== es) begin
        bad++;
        $display("FAIL reset_sq k=%0d got=%h exp=%h", k, sq, es);
      end
    end
  endtask

  task automatic test_reprogram();
    run = 4'hF;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic et;
      logic ep;
      wr_en  = (k == 2);
      wr_ch  = 4'd1;
      wr_div = 8'd6;
      step();
      et = (k == 4) || (k == 10) || (k == 16);
      ep = (k >= 2) && (k <= 3);
      total++;
      if (tick[1] !== et) begin
        bad++;
        $display("FAIL reprog_tick k=%0d got=%b exp=%b", k, tick[1], et);
      end
      total++;
      if (pending[1] !== ep) begin
        bad++;
        $display("FAIL reprog_pending k=%0d got=%b exp=%b", k, pending[1], ep);
      end
    end
    idle_inputs();
  endtask

  task automatic test_zero_one();
    run = 4'hF;
    wr_en = 1'b1; wr_ch = 4'd2; wr_div = 8'd0;
    step();
    wr_ch = 4'd3; wr_div = 8'd1;
    step();
    idle_inputs();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    total++;
    if (pending !== 4'h0) begin
      bad++;
      $display("FAIL zero_one_pending got=%h exp=0", pending);
    end
    for (int k = 1; k <= 6; k++) begin
      logic [1:0] es;
      step();
      es = (k % 2 == 1) ? 2'b11 : 2'b00;
      total++;
      if (tick[3:2] !== 2'b11) begin
        bad++;
        $display("FAIL zero_one_tick k=%0d got=%b exp=11", k, tick[3:2]);
      end
      total++;
      if (sq[3:2] !== es) begin
        bad++;
        $display("FAIL zero_one_sq k=%0d got=%b exp=%b", k, sq[3:2], es);
      end
    end
  endtask

  task automatic test_run_gating();
    run = 4'hF;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      logic et;
      logic es;
      run[0] = !((k >= 7) && (k <= 11));
      step();
      et = (k == 4) || (k == 13);
      es = (k >= 4) && (k < 13);
      total++;
      if (tick[0] !== et) begin
        bad++;
        $display("FAIL gate_tick k=%0d got=%b exp=%b", k, tick[0], et);
      end
      total++;
      if (sq[0] !== es) begin
        bad++;
        $display("FAIL gate_sq k=%0d got=%b exp=%b", k, sq[0], es);
      end
    end
    run = 4'hF;
  endtask

  task automatic test_phase_align();
    int n;
    run = 4'hF;
    wr_en = 1'b1; wr_ch = 4'd1; wr_div = 8'd8;
    step();
    idle_inputs();
    n = $urandom_range(0, 9);
    for (int i = 0; i < n; i++) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    total++;
    if ({tick[1:0], sq[1:0]} !== 4'h0) begin
      bad++;
      $display("FAIL align_clear got=%h exp=0", {tick[1:0], sq[1:0]});
    end
    for (int k = 1; k <= 8; k++) begin
      logic [1:0] et;
      step();
      et = {(k == 8), (k % 4 == 0)};
      total++;
      if (tick[1:0] !== et) begin
        bad++;
        $display("FAIL align_tick k=%0d got=%b exp=%b", k, tick[1:0], et);
      end
    end
  endtask

  task automatic test_collisions();
    int n;
    run = 4'hF;
    n = $urandom_range(3, 7);
    for (int i = 0; i < n; i++) step();
    rst_n = 1'b0; sync_clr = 1'b1;
    wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd2;
    step();
    total++;
    if ({tick, sq, pending} !== 12'h000) begin
      bad++;
      $display("FAIL coll_reset got=%h exp=000", {tick, sq, pending});
    end
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      logic [NC-1:0] et;
      wr_en = (k == 2); wr_ch = 4'd9; wr_div = 8'd1;
      step();
      et = (k % 4 == 0) ? 4'hF : 4'h0;
      total++;
      if (tick !== et) begin
        bad++;
        $display("FAIL coll_default_tick k=%0d got=%h exp=%h", k, tick, et);
      end
      total++;
      if (pending !== 4'h0) begin
        bad++;
        $display("FAIL coll_badch_pending k=%0d got=%h exp=0", k, pending);
      end
    end
    sync_clr = 1'b1; wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd3;
    step();
    idle_inputs();
    total++;
    if (pending !== 4'h0) begin
      bad++;
      $display("FAIL coll_clrwr_pending got=%h exp=0", pending);
    end
    for (int k = 1; k <= 6; k++) begin
      logic et;
      step();
      et = (k % 3 == 0);
      total++;
      if (tick[0] !== et) begin
        bad++;
        $display("FAIL coll_clrwr_tick k=%0d got=%b exp=%b", k, tick[0], et);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      run      = 4'($urandom) | 4'($urandom);
      rst_n    = ($urandom_range(0, 199) != 0);
      sync_clr = ($urandom_range(0, 39) == 0);
      wr_en    = ($urandom_range(0, 4) == 0);
      wr_ch    = 4'($urandom_range(0, 9));
      wr_div   = 8'($urandom_range(0, 9));
      step();
      total++;
      if (tick !== m_tick) begin
        bad++;
        $display("FAIL rand_tick k=%0d got=%h exp=%h", k, tick, m_tick);
      end
      total++;
      if (sq !== m_sq) begin
        bad++;
        $display("FAIL rand_sq k=%0d got=%h exp=%h", k, sq, m_sq);
      end
      total++;
      if (pending !== m_pend) begin
        bad++;
        $display("FAIL rand_pending k=%0d got=%h exp=%h", k, pending, m_pend);
      end
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    run   = '0;
    idle_inputs();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_div[c] = DD; m_shd[c] = DD;
    end
    m_tick = '0; m_sq = '0; m_pend = '0;
    @(negedge ckht);
    test_reset();
    test_reprogram();
    test_zero_one();
    test_run_gating();
    test_phase_align();
    test_collisions();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
